hazard_scoreboard: RTL and testbench

Parametrised in-flight destination tracker sitting between decode and the execute/memory/writeback stages. It replaces the fixed triple-flopped RD/RegWrt chain in decode with a DEPTH-entry shift pipeline of (valid, rd, wr, is_load) records. It compares decode's source selects against every in-flight record and produces a load-use/RAW stall plus per-source forwarding hit and stage. A forwarding-enable mode, per-stage flush and a global freeze are provided; the fixed chain has none of these.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 tb/tb_hazard_scoreboard.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for the hazard scoreboard: decode drives the master side,
// the scoreboard answers with stall/forwarding/busy/writeback on the slave side.
interface hazard_scoreboard_if #(
    parameter int REG_W = 3,
    parameter int DEPTH = 3,
    parameter int NSRC  = 2,
    parameter int SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
    logic                    id_valid;
    logic                    id_wr;
    logic [REG_W-1:0]        id_rd;
    logic                    id_is_load;
    logic [NSRC*REG_W-1:0]   id_src_sel;
    logic [NSRC-1:0]         id_src_used;
    logic                    flush_id;
    logic [DEPTH-1:0]        flush_mask;
    logic                    ext_stall;

    logic                    stall;
    logic [NSRC-1:0]         fwd_hit;
    logic [NSRC*SW-1:0]      fwd_stage;
    logic [(1<<REG_W)-1:0]   busy;
    logic                    wb_wr;
    logic [REG_W-1:0]        wb_rd;

    modport master (
        output id_valid, id_wr, id_rd, id_is_load, id_src_sel, id_src_used,
               flush_id, flush_mask, ext_stall,
        input  stall, fwd_hit, fwd_stage, busy, wb_wr, wb_rd
    );

    modport slave (
        input  id_valid, id_wr, id_rd, id_is_load, id_src_sel, id_src_used,
               flush_id, flush_mask, ext_stall,
        output stall, fwd_hit, fwd_stage, busy, wb_wr, wb_rd
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: a DEPTH-stage shift pipeline of writer records
// that yields RAW/load-use stall, per-source forwarding hit/stage and busy bits.
module hazard_scoreboard #(
    parameter int REG_W      = 3,
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int FWD_EN     = 1,
    parameter int LOAD_STAGE = 1
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave sb
);
    localparam int NREG = 1 << REG_W;
    localparam int SW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] wr_q,    wr_d;
    logic [DEPTH-1:0] load_q,  load_d;
    logic [REG_W-1:0] rd_q [DEPTH];
    logic [REG_W-1:0] rd_d [DEPTH];

    logic [DEPTH-1:0]   ready;
    logic [NSRC-1:0]    hit;
    logic [NSRC-1:0]    block;
    logic [NSRC*SW-1:0] stage_sel;
    logic [NREG-1:0]    busy;
    logic               stall;
    logic               ins_valid;

    // The record leaving the last stage is always covered by the regfile bypass.
    always_comb begin
        ready = '0;
        for (int s = 0; s < DEPTH; s++) begin
            ready[s] = (s == DEPTH - 1) ||
                       ((FWD_EN != 0) && (!load_q[s] || (s >= LOAD_STAGE)));
        end
    end

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit       = '0;
        block     = '0;
        stage_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (valid_q[s] && wr_q[s] && sb.id_src_used[i] &&
                    (rd_q[s] == sb.id_src_sel[i*REG_W +: REG_W])) begin
                    hit[i]               = 1'b1;
                    block[i]             = !ready[s];
                    stage_sel[i*SW +: SW] = SW'(s);
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (valid_q[s] && wr_q[s]) begin
                busy[rd_q[s]] = 1'b1;
            end
        end
    end

    assign stall     = sb.id_valid && !sb.flush_id && (|block);
    assign ins_valid = sb.id_valid && !stall && !sb.flush_id;

    // Flushed records keep moving as bubbles; a freeze holds them in place.
    always_comb begin
        valid_d = valid_q & ~sb.flush_mask;
        wr_d    = wr_q;
        load_d  = load_q;
        rd_d    = rd_q;
        if (!sb.ext_stall) begin
            valid_d[0] = ins_valid;
            wr_d[0]    = sb.id_wr;
            load_d[0]  = sb.id_is_load;
            rd_d[0]    = sb.id_rd;
            for (int s = 1; s < DEPTH; s++) begin
                valid_d[s] = valid_q[s-1] && !sb.flush_mask[s-1];
                wr_d[s]    = wr_q[s-1];
                load_d[s]  = load_q[s-1];
                rd_d[s]    = rd_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            wr_q    <= '0;
            load_q  <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                rd_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
            for (int s = 0; s < DEPTH; s++) begin
                rd_q[s] <= rd_d[s];
            end
        end
    end

    assign sb.stall     = stall;
    assign sb.fwd_hit   = hit;
    assign sb.fwd_stage = stage_sel;
    assign sb.busy      = busy;
    assign sb.wb_wr     = valid_q[DEPTH-1] && wr_q[DEPTH-1];
    assign sb.wb_rd     = rd_q[DEPTH-1];
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a forwarding instance (LOAD_STAGE=1)
// and a stall-until-writeback instance share one decode stimulus stream.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_scoreboard_if #(.REG_W(3), .DEPTH(3), .NSRC(2)) busF ();
    hazard_scoreboard_if #(.REG_W(3), .DEPTH(3), .NSRC(2)) busS ();

    hazard_scoreboard #(.REG_W(3), .DEPTH(3), .NSRC(2), .FWD_EN(1), .LOAD_STAGE(1)) dutFwd (
        .clk (clk),
        .rst (rst),
        .sb  (busF.slave)
    );

    hazard_scoreboard #(.REG_W(3), .DEPTH(3), .NSRC(2), .FWD_EN(0), .LOAD_STAGE(1)) dutStall (
        .clk (clk),
        .rst (rst),
        .sb  (busS.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives the same decode record into both instances, then lets logic settle.
    task automatic applyStimulus(input logic v, input logic wr, input logic ld,
                                 input logic [2:0] rd,
                                 input logic [2:0] s0, input logic u0,
                                 input logic [2:0] s1, input logic u1);
        busF.id_valid    = v;   busS.id_valid    = v;
        busF.id_wr       = wr;  busS.id_wr       = wr;
        busF.id_is_load  = ld;  busS.id_is_load  = ld;
        busF.id_rd       = rd;  busS.id_rd       = rd;
        busF.id_src_sel  = {s1, s0};
        busS.id_src_sel  = {s1, s0};
        busF.id_src_used = {u1, u0};
        busS.id_src_used = {u1, u0};
        #1;
    endtask

    task automatic setControl(input logic fid, input logic [2:0] fm, input logic es);
        busF.flush_id = fid;  busS.flush_id = fid;
        busF.flush_mask = fm; busS.flush_mask = fm;
        busF.ext_stall = es;  busS.ext_stall = es;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        setControl(1'b0, 3'b000, 1'b0);
        applyStimulus(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        setControl(1'b0, 3'b000, 1'b0);
        applyStimulus(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);

        checkOutput("reset_stall",  32'(busF.stall),   32'h0);
        checkOutput("reset_hit",    32'(busF.fwd_hit), 32'h0);
        checkOutput("reset_stage",  32'(busF.fwd_stage), 32'h0);
        checkOutput("reset_busy",   32'(busF.busy),    32'h0);
        checkOutput("reset_wb_wr",  32'(busF.wb_wr),   32'h0);
        checkOutput("reset_wb_rd",  32'(busF.wb_rd),   32'h0);
        #2;
        rst = 1'b1;

        // Fill three stages with writers r1,r2,r3 then reset between edges.
        applyStimulus(1, 1, 0, 3'd1, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(1, 1, 0, 3'd2, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(1, 1, 0, 3'd3, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        checkOutput("fill_busy",  32'(busF.busy),  32'h0E);
        checkOutput("fill_wb_wr", 32'(busF.wb_wr), 32'h1);
        checkOutput("fill_wb_rd", 32'(busF.wb_rd), 32'h1);
        rst = 1'b0;
        #1;
        checkOutput("async_busy",  32'(busF.busy),  32'h0);
        checkOutput("async_wb_wr", 32'(busF.wb_wr), 32'h0);
        rst = 1'b1;
        applyStimulus(1, 0, 0, 3'd0, 3'd1, 1, 3'd0, 0);
        checkOutput("post_rst_stall", 32'(busF.stall),   32'h0);
        checkOutput("post_rst_hit",   32'(busF.fwd_hit), 32'h0);
        tick();

        // ALU RAW with forwarding.
        resetDut();
        applyStimulus(1, 1, 0, 3'd3, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(1, 0, 0, 3'd0, 3'd3, 1, 3'd0, 0);
        checkOutput("raw_stall",  32'(busF.stall),          32'h0);
        checkOutput("raw_hit",    32'(busF.fwd_hit),        32'h1);
        checkOutput("raw_stage0", 32'(busF.fwd_stage[1:0]), 32'h0);
        tick();
        applyStimulus(1, 0, 0, 3'd0, 3'd3, 1, 3'd0, 0);
        checkOutput("raw_stage1", 32'(busF.fwd_stage[1:0]), 32'h1);
        checkOutput("raw_hit1",   32'(busF.fwd_hit),        32'h1);
        tick();

        // Load-use on port 1: one stall cycle, bubble inserted.
        resetDut();
        applyStimulus(1, 1, 1, 3'd2, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(1, 1, 0, 3'd6, 3'd0, 0, 3'd2, 1);
        checkOutput("lu_stall",  32'(busF.stall),          32'h1);
        checkOutput("lu_hit",    32'(busF.fwd_hit),        32'h2);
        checkOutput("lu_stage",  32'(busF.fwd_stage[3:2]), 32'h0);
        tick();
        applyStimulus(1, 1, 0, 3'd6, 3'd0, 0, 3'd2, 1);
        checkOutput("lu_stall2", 32'(busF.stall),          32'h0);
        checkOutput("lu_stage2", 32'(busF.fwd_stage[3:2]), 32'h1);
        checkOutput("lu_bubble", 32'(busF.busy),           32'h04);
        tick();
        applyStimulus(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        checkOutput("lu_busy3",  32'(busF.busy),  32'h44);
        checkOutput("lu_wb_wr",  32'(busF.wb_wr), 32'h1);
        checkOutput("lu_wb_rd",  32'(busF.wb_rd), 32'h2);
        tick();

        // Stall-until-writeback mode: DEPTH-1 stall cycles.
        resetDut();
        applyStimulus(1, 1, 0, 3'd5, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(1, 0, 0, 3'd0, 3'd5, 1, 3'd0, 0);
        checkOutput("nofwd_stall1", 32'(busS.stall), 32'h1);
        tick();
        applyStimulus(1, 0, 0, 3'd0, 3'd5, 1, 3'd0, 0);
        checkOutput("nofwd_stall2", 32'(busS.stall), 32'h1);
        tick();
        applyStimulus(1, 0, 0, 3'd0, 3'd5, 1, 3'd0, 0);
        checkOutput("nofwd_stall3", 32'(busS.stall),          32'h0);
        checkOutput("nofwd_wb_wr",  32'(busS.wb_wr),          32'h1);
        checkOutput("nofwd_wb_rd",  32'(busS.wb_rd),          32'h5);
        checkOutput("nofwd_stage",  32'(busS.fwd_stage[1:0]), 32'h2);
        tick();

        // Youngest priority: load in stage 0 decides even with ALU r1 in stage 2.
        resetDut();
        applyStimulus(1, 1, 0, 3'd1, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(1, 1, 1, 3'd1, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(1, 0, 0, 3'd0, 3'd1, 1, 3'd0, 0);
        checkOutput("young_ld_stall", 32'(busF.stall),          32'h1);
        checkOutput("young_ld_stage", 32'(busF.fwd_stage[1:0]), 32'h0);
        tick();
        resetDut();
        applyStimulus(1, 1, 0, 3'd1, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(1, 1, 0, 3'd1, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(1, 0, 0, 3'd0, 3'd1, 1, 3'd0, 0);
        checkOutput("young_alu_stall", 32'(busF.stall),          32'h0);
        checkOutput("young_alu_stage", 32'(busF.fwd_stage[1:0]), 32'h0);
        tick();

        // Flush of the blocking load, then a two-cycle freeze.
        resetDut();
        applyStimulus(1, 1, 1, 3'd4, 3'd0, 0, 3'd0, 0); tick();
        setControl(1'b0, 3'b001, 1'b0);
        applyStimulus(1, 1, 0, 3'd7, 3'd4, 1, 3'd0, 0);
        checkOutput("flush_stall_now", 32'(busF.stall), 32'h1);
        tick();
        setControl(1'b0, 3'b000, 1'b0);
        applyStimulus(1, 1, 0, 3'd7, 3'd4, 1, 3'd0, 0);
        checkOutput("flush_busy",  32'(busF.busy),  32'h00);
        checkOutput("flush_stall", 32'(busF.stall), 32'h0);
        tick();
        applyStimulus(1, 1, 0, 3'd2, 3'd0, 0, 3'd0, 0); tick();
        applyStimulus(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0); tick();
        checkOutput("pre_frz_busy",  32'(busF.busy),  32'h84);
        checkOutput("pre_frz_wb_wr", 32'(busF.wb_wr), 32'h1);
        checkOutput("pre_frz_wb_rd", 32'(busF.wb_rd), 32'h7);
        setControl(1'b0, 3'b000, 1'b1);
        applyStimulus(1, 1, 0, 3'd3, 3'd0, 0, 3'd0, 0);
        tick();
        checkOutput("frz1_busy",  32'(busF.busy),  32'h84);
        checkOutput("frz1_wb_rd", 32'(busF.wb_rd), 32'h7);
        tick();
        checkOutput("frz2_busy",  32'(busF.busy),  32'h84);
        checkOutput("frz2_wb_wr", 32'(busF.wb_wr), 32'h1);
        checkOutput("frz2_wb_rd", 32'(busF.wb_rd), 32'h7);
        setControl(1'b0, 3'b000, 1'b0);
        applyStimulus(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        tick();
        checkOutput("thaw_busy",  32'(busF.busy),  32'h04);
        checkOutput("thaw_wb_wr", 32'(busF.wb_wr), 32'h1);
        checkOutput("thaw_wb_rd", 32'(busF.wb_rd), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
